// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM tag engine: block/length widths,
// sequencer states, block-type codes, byte masking and the length block.
package gcm_pkg;

    localparam int GCM_BLK_BITS = 128;
    localparam int LEN_BITS     = 64;

    localparam logic BLK_AAD = 1'b0;
    localparam logic BLK_CT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AAD,
        ST_CT,
        ST_LEN,
        ST_FINAL
    } state_t;

    // Byte 0 sits in bits 127:120, so valid bytes fill the mask from the MSB down.
    function automatic logic [GCM_BLK_BITS-1:0] byte_mask(input logic [4:0] nbytes);
        logic [GCM_BLK_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < GCM_BLK_BITS / 8; i++) begin
            if (5'(i) < nbytes) m[GCM_BLK_BITS-1-8*i -: 8] = 8'hff;
        end
        return m;
    endfunction

    function automatic logic [GCM_BLK_BITS-1:0] len_block(input logic [LEN_BITS-1:0] a_bytes,
                                                          input logic [LEN_BITS-1:0] c_bytes);
        return {a_bytes << 3, c_bytes << 3};
    endfunction

endpackage

// File: rtl/gcm_tag_engine_gfm.sv
// Digit-serial GF(2^128) multiplier in GCM bit order: one en pulse loads a/b,
// result is valid while done pulses GFM_CYCLES+1 cycles later.
module gfm #(
    parameter int                  GFM_BITS   = 128,
    parameter logic [GFM_BITS-1:0] POLYNOMIAL = 128'he1 << 120,
    parameter int                  GFM_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [GFM_BITS-1:0] a,
    input  logic [GFM_BITS-1:0] b,
    output logic [GFM_BITS-1:0] result,
    output logic                done
);

    localparam int DIGIT = GFM_BITS / GFM_CYCLES;
    localparam int CW    = $clog2(GFM_CYCLES + 1);

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GFM_BITS-1:0] x_q, x_d;
    logic [GFM_BITS-1:0] v_q, v_d;
    logic [GFM_BITS-1:0] z_q, z_d;

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        x_d    = x_q;
        v_d    = v_q;
        z_d    = z_q;
        if (busy_q) begin
            // NOTE: blocking '=' here lets each loop step build on the previous one within
            // the cycle; only the always_ff blocks use '<='.
            for (int i = 0; i < DIGIT; i++) begin
                if (x_d[GFM_BITS-1]) z_d = z_d ^ v_d;
                v_d = v_d[0] ? ((v_d >> 1) ^ POLYNOMIAL) : (v_d >> 1);
                x_d = x_d << 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(GFM_CYCLES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (en) begin
            x_d    = a;
            v_d    = b;
            z_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: operand/accumulator registers carry no reset; they are always loaded by en
    // before being read, and done (which qualifies result) is reset.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        v_q <= v_d;
        z_q <= z_d;
    end

    assign result = z_q;
    assign done   = done_q;

endmodule

// File: rtl/gcm_tag_engine.sv
// GHASH sequencer for one AES-GCM message: hashes AAD then ciphertext blocks,
// folds in the length block, XORs E(K,J0) and emits or verifies the tag.
module gcm_tag_engine
    import gcm_pkg::*;
#(
    parameter int GFM_CYCLES = 8,
    parameter int TAG_BITS   = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [GCM_BLK_BITS-1:0] subkey_H,
    input  logic [GCM_BLK_BITS-1:0] ek_j0,
    input  logic [GCM_BLK_BITS-1:0] exp_tag,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    input  logic [GCM_BLK_BITS-1:0] blk_data,
    input  logic                    blk_type,
    input  logic [4:0]              blk_bytes,
    input  logic                    blk_last,
    output logic                    busy,
    output logic [GCM_BLK_BITS-1:0] tag_out,
    output logic                    tag_valid,
    output logic                    tag_match,
    output logic                    err
);

    localparam logic [GCM_BLK_BITS-1:0] TAG_MASK = {GCM_BLK_BITS{1'b1}} << (GCM_BLK_BITS - TAG_BITS);

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [GCM_BLK_BITS-1:0] h_q, h_d;
    logic [GCM_BLK_BITS-1:0] ekj0_q, ekj0_d;
    logic [GCM_BLK_BITS-1:0] exp_q, exp_d;
    logic [GCM_BLK_BITS-1:0] acc_q, acc_d;
    logic [LEN_BITS-1:0]     lena_q, lena_d;
    logic [LEN_BITS-1:0]     lenc_q, lenc_d;
    logic                    pend_q, pend_d;
    logic                    last_pend_q, last_pend_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic [GCM_BLK_BITS-1:0] tag_out_q, tag_out_d;
    logic                    tag_valid_q, tag_valid_d;
    logic                    tag_match_q, tag_match_d;
    logic                    err_q, err_d;

    logic                    gfm_en;
    logic [GCM_BLK_BITS-1:0] gfm_a;
    logic [GCM_BLK_BITS-1:0] gfm_result;
    logic                    gfm_done;

    logic                    accept;
    logic                    blk_ok;
    logic [GCM_BLK_BITS-1:0] masked_blk;

    assign accept     = blk_valid & ready_q;
    assign masked_blk = blk_data & byte_mask(blk_bytes);
    assign blk_ok     = (blk_bytes <= 5'd16)
                     && ((blk_bytes == 5'd16) || blk_last)
                     && !((state_q == ST_CT) && (blk_type == BLK_AAD));

    gfm #(
        .GFM_BITS   (GCM_BLK_BITS),
        .POLYNOMIAL (128'he1 << 120),
        .GFM_CYCLES (GFM_CYCLES)
    ) u_gfm (
        .clk    (clk),
        .reset  (reset),
        .en     (gfm_en),
        .a      (gfm_a),
        .b      (h_q),
        .result (gfm_result),
        .done   (gfm_done)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        h_d         = h_q;
        ekj0_d      = ekj0_q;
        exp_d       = exp_q;
        acc_d       = acc_q;
        lena_d      = lena_q;
        lenc_d      = lenc_q;
        pend_d      = pend_q;
        last_pend_d = last_pend_q;
        tag_out_d   = tag_out_q;
        tag_valid_d = 1'b0;
        tag_match_d = tag_match_q;
        err_d       = err_q;
        gfm_en      = 1'b0;
        gfm_a       = acc_q ^ masked_blk;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    h_d         = subkey_H;
                    ekj0_d      = ek_j0;
                    exp_d       = exp_tag;
                    acc_d       = '0;
                    lena_d      = '0;
                    lenc_d      = '0;
                    pend_d      = 1'b0;
                    last_pend_d = 1'b0;
                    tag_out_d   = '0;
                    tag_match_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_AAD;
                end
            end
            ST_AAD, ST_CT: begin
                if (pend_q) begin
                    if (gfm_done) begin
                        acc_d       = gfm_result;
                        pend_d      = 1'b0;
                        last_pend_d = 1'b0;
                        if (last_pend_q) state_d = ST_LEN;
                    end
                end else if (accept) begin
                    if (!blk_ok) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        if (blk_type == BLK_CT) begin
                            state_d = ST_CT;
                            lenc_d  = lenc_q + LEN_BITS'(blk_bytes);
                        end else begin
                            lena_d  = lena_q + LEN_BITS'(blk_bytes);
                        end
                        if (blk_bytes != 5'd0) begin
                            gfm_en      = 1'b1;
                            pend_d      = 1'b1;
                            last_pend_d = blk_last;
                        end else begin
                            state_d = ST_LEN;   // empty terminator: blk_ok already implies blk_last
                        end
                    end
                end
            end
            ST_LEN: begin
                gfm_a = acc_q ^ len_block(lena_q, lenc_q);
                if (!pend_q) begin
                    gfm_en = 1'b1;
                    pend_d = 1'b1;
                end else if (gfm_done) begin
                    acc_d   = gfm_result;
                    pend_d  = 1'b0;
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                // Two cycles: compute, then hold FINAL while the tag_valid pulse is visible.
                if (!tag_valid_q) begin
                    tag_out_d   = acc_q ^ ekj0_q;
                    tag_valid_d = 1'b1;
                    tag_match_d = mode_q && ((tag_out_d & TAG_MASK) == (exp_q & TAG_MASK));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = ((state_d == ST_AAD) || (state_d == ST_CT)) && !pend_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            h_q         <= '0;
            ekj0_q      <= '0;
            exp_q       <= '0;
            acc_q       <= '0;
            lena_q      <= '0;
            lenc_q      <= '0;
            pend_q      <= 1'b0;
            last_pend_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            tag_out_q   <= '0;
            tag_valid_q <= 1'b0;
            tag_match_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            h_q         <= h_d;
            ekj0_q      <= ekj0_d;
            exp_q       <= exp_d;
            acc_q       <= acc_d;
            lena_q      <= lena_d;
            lenc_q      <= lenc_d;
            pend_q      <= pend_d;
            last_pend_q <= last_pend_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            tag_out_q   <= tag_out_d;
            tag_valid_q <= tag_valid_d;
            tag_match_q <= tag_match_d;
            err_q       <= err_d;
        end
    end

    assign blk_ready = ready_q;
    assign busy      = busy_q;
    assign tag_out   = tag_out_q;
    assign tag_valid = tag_valid_q;
    assign tag_match = tag_match_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gcm_tag_engine.sv
// Directed self-checking bench for gcm_tag_engine using the GCM test-case-2 key material.
module tb_gcm_tag_engine;

    localparam int G = 8;
    localparam logic [127:0] H_K  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EK   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C2   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] A1   = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    localparam logic [127:0] RPOL = 128'he1 << 120;

    logic         clk = 1'b0;
    logic         reset, start, mode;
    logic [127:0] subkey_H, ek_j0, exp_tag, blk_data;
    logic         blk_valid, blk_type, blk_last;
    logic [4:0]   blk_bytes;

    logic         blk_ready, busy, tag_valid, tag_match, err;
    logic [127:0] tag_out;
    logic         blk_ready_96, busy_96, tag_valid_96, tag_match_96, err_96;
    logic [127:0] tag_out_96;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic         seen;
    int           tcyc;
    logic [127:0] got_tag;
    logic         got_match, got_match96, got_err;

    gcm_tag_engine #(.GFM_CYCLES(G), .TAG_BITS(128)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .subkey_H(subkey_H),
        .ek_j0(ek_j0), .exp_tag(exp_tag), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_type(blk_type), .blk_bytes(blk_bytes), .blk_last(blk_last),
        .busy(busy), .tag_out(tag_out), .tag_valid(tag_valid), .tag_match(tag_match), .err(err)
    );

    gcm_tag_engine #(.GFM_CYCLES(G), .TAG_BITS(96)) dut96 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .subkey_H(subkey_H),
        .ek_j0(ek_j0), .exp_tag(exp_tag), .blk_valid(blk_valid), .blk_ready(blk_ready_96),
        .blk_data(blk_data), .blk_type(blk_type), .blk_bytes(blk_bytes), .blk_last(blk_last),
        .busy(busy_96), .tag_out(tag_out_96), .tag_valid(tag_valid_96), .tag_match(tag_match_96),
        .err(err_96)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z, v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ RPOL) : (v >> 1);
        end
        return z;
    endfunction

    task automatic begin_msg(input logic m, input logic [127:0] e);
        @(posedge clk);
        #1 start = 1'b1; mode = m; exp_tag = e;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input logic t, input logic [4:0] n,
                              input logic l, output int acc_cyc);
        blk_data = d; blk_type = t; blk_bytes = n; blk_last = l; blk_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (blk_ready) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (acc_cyc >= 0) break;
        end
        blk_valid = 1'b0; blk_last = 1'b0;
        check("block_accepted", 128'(acc_cyc >= 0), 128'd1);
    endtask

    task automatic wait_tag(input int budget);
        seen = 1'b0;
        tcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tag_valid) begin
                seen = 1'b1; tcyc = cyc; got_tag = tag_out;
                got_match = tag_match; got_match96 = tag_match_96; got_err = err;
                break;
            end
        end
    endtask

    initial begin
        int a0;
        int accs [4];
        int k;
        logic [127:0] x1, x2, x3, want;

        reset = 1'b1; start = 1'b0; mode = 1'b0; subkey_H = H_K; ek_j0 = EK; exp_tag = '0;
        blk_data = '0; blk_valid = 1'b0; blk_type = 1'b0; blk_bytes = '0; blk_last = 1'b0;

        // Reset wins over start and blk_valid asserted alongside it.
        repeat (2) @(posedge clk);
        #1 start = 1'b1; blk_valid = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0; blk_valid = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", blk_ready, 0);
        check("rst_tag_valid", tag_valid, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_tag_match", tag_match, 0);
        check("rst_err", err, 0);

        // Empty message: tag is E(K,J0).
        begin_msg(1'b0, '0);
        check("busy_after_start", busy, 1);
        send_block('0, 1'b1, 5'd0, 1'b1, a0);
        wait_tag(60);
        check("empty_seen", seen, 1);
        check("empty_tag", got_tag, EK);
        check("empty_err", got_err, 0);

        // One full CT block, generate mode, plus latency and start-during-tag_valid.
        begin_msg(1'b0, '0);
        send_block(C2, 1'b1, 5'd16, 1'b1, a0);
        wait_tag(60);
        check("ct_seen", seen, 1);
        check("ct_tag", got_tag, T2);
        check("ct_match_gen", got_match, 0);
        check("ct_latency", 128'(tcyc - a0), 128'(2 * (G + 2) + 1));
        check("busy_at_tag", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_in_final_ignored", busy, 0);

        // Verify mode: exact tag, then bit 0 flipped (ignored when only 96 bits compared).
        begin_msg(1'b1, T2);
        send_block(C2, 1'b1, 5'd16, 1'b1, a0);
        wait_tag(60);
        check("vfy_match128", got_match, 1);
        check("vfy_match96", got_match96, 1);
        begin_msg(1'b1, T2 ^ 128'd1);
        send_block(C2, 1'b1, 5'd16, 1'b1, a0);
        wait_tag(60);
        check("vfy_flip_match128", got_match, 0);
        check("vfy_flip_match96", got_match96, 1);
        check("vfy_flip_tag", got_tag, T2);

        // Order violation: CT then AAD.
        begin_msg(1'b0, '0);
        send_block(C2, 1'b1, 5'd16, 1'b0, a0);
        send_block(A1, 1'b0, 5'd16, 1'b1, a0);
        check("order_err", err, 1);
        check("order_busy", busy, 0);
        wait_tag(40);
        check("order_no_tag", seen, 0);
        begin_msg(1'b0, '0);
        check("start_clears_err", err, 0);
        // Oversized byte count on the first block of that message.
        send_block(C2, 1'b1, 5'd17, 1'b1, a0);
        check("bytes17_err", err, 1);
        check("bytes17_busy", busy, 0);

        // Partial last block with junk beyond byte 4, then the zero-padded equivalent.
        x1   = gmul({40'h0388dace60, 88'h0}, H_K);
        x2   = gmul(x1 ^ {64'd0, 64'd40}, H_K);
        want = x2 ^ EK;
        begin_msg(1'b0, '0);
        send_block({40'h0388dace60, 88'haa55aa55aa55aa55aa55aa}, 1'b1, 5'd5, 1'b1, a0);
        wait_tag(60);
        check("partial_junk_tag", got_tag, want);
        check("partial_err_cleared", got_err, 0);
        check("partial_lenc_bits", {dut.lenc_q, 3'b000}, 128'd40);
        begin_msg(1'b0, '0);
        send_block({40'h0388dace60, 88'h0}, 1'b1, 5'd5, 1'b1, a0);
        wait_tag(60);
        check("partial_zero_tag", got_tag, want);

        // AAD block followed by a CT block.
        x1   = gmul(A1, H_K);
        x2   = gmul(x1 ^ C2, H_K);
        x3   = gmul(x2 ^ {64'd128, 64'd128}, H_K);
        want = x3 ^ EK;
        begin_msg(1'b0, '0);
        send_block(A1, 1'b0, 5'd16, 1'b0, a0);
        send_block(C2, 1'b1, 5'd16, 1'b1, a0);
        wait_tag(60);
        check("aad_ct_tag", got_tag, want);

        // blk_valid held high: four CT blocks, then reset during the last multiply.
        begin_msg(1'b0, '0);
        blk_data = C2; blk_type = 1'b1; blk_bytes = 5'd16; blk_last = 1'b0; blk_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            if (blk_ready) begin
                accs[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            if (k == 3) blk_last = 1'b1;
        end
        blk_valid = 1'b0; blk_last = 1'b0;
        check("b2b_count", k, 4);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 128'(accs[i] - accs[i-1]), 128'(G + 2));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_ready", blk_ready, 0);
        wait_tag(40);
        check("midrst_no_tag", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
